param_multicycle_cpu: RTL

//  Next-generation core: multi-cycle load/store processor, parametrised in data width, register count, data-memory depth.

---
 rtl/param_multicycle_cpu_pkg.sv | 17 +
 rtl/param_multicycle_cpu_regfile.sv | 27 ++
 rtl/param_multicycle_cpu.sv | 129 ++++++++++++
 3 files changed

// File: rtl/param_multicycle_cpu_pkg.sv
// param_multicycle_cpu_pkg: opcodes, FSM state encoding and instruction field offsets shared by the multi-cycle core
package param_multicycle_cpu_pkg;
  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_BR    = 2'b11;
  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;
  function automatic int rt_lo(input int aw);
    return aw;
  endfunction
  function automatic int rs_lo(input int aw);
    return 2 * aw;
  endfunction
  function automatic int op_lo(input int aw);
    return 3 * aw;
  endfunction
endpackage

// File: rtl/param_multicycle_cpu_regfile.sv
// cpu_regfile: NUM_REGS x DATA_W GPRs; ports clock, reset (sync active-low clear), two async reads (raddr/rdata a,b), one sync write (we, waddr, wdata)
module cpu_regfile #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [AW-1:0]     raddr_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata
);
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  assign rdata_a = regs_q[raddr_a];
  assign rdata_b = regs_q[raddr_b];
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (we) begin
      regs_q[waddr] <= wdata;
    end
  end
endmodule

// File: rtl/param_multicycle_cpu.sv
// param_multicycle_cpu: multi-cycle ADD/LOAD/STORE/BRANCH core with req/ack fetch, console strobe, halt on self-branch
//   ports: clock, reset (sync active-low), imem_addr/imem_req/imem_ack/imem_data fetch port,
//   console_data/console_valid GPR-write console, halted, mem_fault (sticky); BEQ_EN makes BRANCH conditional on R[rs]==R[rt]
module param_multicycle_cpu
  import param_multicycle_cpu_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int NUM_REGS  = 4,
  parameter int MEM_DEPTH = 32,
  parameter int PC_W      = 8,
  localparam int REG_AW   = $clog2(NUM_REGS),
  localparam int INSTR_W  = 2 + 3 * REG_AW
) (
  input  logic               clock,
  input  logic               reset,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_req,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [DATA_W-1:0]  console_data,
  output logic               console_valid,
  output logic               halted,
  output logic               mem_fault
);
  localparam int MA_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  state_t state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc, br_target, imm_p;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] console_data_q, console_data_d;
  logic console_valid_q, console_valid_d, halted_q, halted_d, mem_fault_q, mem_fault_d;
  logic [DATA_W-1:0] dmem_q [MEM_DEPTH];
  logic [1:0] op;
  logic [REG_AW-1:0] rs, rt, rd, waddr;
  logic [DATA_W-1:0] rdata_s, rdata_t, imm_w, addr, wdata;
  logic [MA_W-1:0] mem_idx;
  logic in_range, we, dm_we, taken;
  assign op = ir_q[op_lo(REG_AW) +: 2];
  assign rs = ir_q[rs_lo(REG_AW) +: REG_AW];
  assign rt = ir_q[rt_lo(REG_AW) +: REG_AW];
  assign rd = ir_q[REG_AW-1:0];
  assign imm_w = {{(DATA_W-REG_AW){rd[REG_AW-1]}}, rd};
  assign imm_p = {{(PC_W-REG_AW){rd[REG_AW-1]}}, rd};
  assign addr = rdata_s + imm_w;
  assign in_range = {1'b0, addr} < (DATA_W+1)'(MEM_DEPTH);
  assign mem_idx = addr[MA_W-1:0];
  assign pc_inc = pc_q + PC_W'(1);
  assign br_target = pc_inc + imm_p;
`ifdef BEQ_EN
  assign taken = rdata_s == rdata_t;
`else
  assign taken = 1'b1;
`endif
  cpu_regfile #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_regfile (
    .clock(clock), .reset(reset),
    .raddr_a(rs), .raddr_b(rt), .rdata_a(rdata_s), .rdata_b(rdata_t),
    .we(we), .waddr(waddr), .wdata(wdata)
  );
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ir_d = ir_q;
    we = 1'b0;
    waddr = rd;
    wdata = rdata_s + rdata_t;
    dm_we = 1'b0;
    mem_fault_d = mem_fault_q;
    case (state_q)
      S_FETCH: begin
        ir_d = imem_ack ? imem_data : ir_q;
        state_d = imem_ack ? S_EXEC : S_FETCH;
      end
      S_EXEC: begin
        case (op)
          OP_ADD: begin
            we = 1'b1;
            pc_d = pc_inc;
            state_d = S_FETCH;
          end
          OP_BR: begin
            pc_d = taken ? br_target : pc_inc;
            // imm == -1 means the target is this very instruction
            state_d = (taken && &rd) ? S_HALT : S_FETCH;
          end
          default: state_d = S_MEM;
        endcase
      end
      S_MEM: begin
        pc_d = pc_inc;
        state_d = S_FETCH;
        mem_fault_d = mem_fault_q | ~in_range;
        we = op == OP_LOAD;
        waddr = rt;
        wdata = in_range ? dmem_q[mem_idx] : '0;
        dm_we = op == OP_STORE && in_range;
      end
      default: ;
    endcase
    halted_d = state_d == S_HALT;
    console_valid_d = we;
    console_data_d = we ? wdata : console_data_q;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_FETCH;
      pc_q <= '0;
      ir_q <= '0;
      console_data_q <= '0;
      console_valid_q <= 1'b0;
      halted_q <= 1'b0;
      mem_fault_q <= 1'b0;
      for (int i = 0; i < MEM_DEPTH; i++) dmem_q[i] <= DATA_W'(i);
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      console_data_q <= console_data_d;
      console_valid_q <= console_valid_d;
      halted_q <= halted_d;
      mem_fault_q <= mem_fault_d;
      if (dm_we) dmem_q[mem_idx] <= rdata_t;
    end
  end
  assign imem_addr = pc_q;
  assign imem_req = reset && state_q == S_FETCH;
  assign console_data = console_data_q;
  assign console_valid = console_valid_q;
  assign halted = halted_q;
  assign mem_fault = mem_fault_q;
endmodule
